// File: rtl/comparator_array.sv
// comparator_array: per-column golden-answer comparator with sticky fault flags and first-fail capture
module comparator_array #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int DATA_WIDTH    = 24,
  parameter int IDX_WIDTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                end_test,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               correct_answer,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] com_ps,
  input  logic [SYSTOLIC_SIZE-1:0]            col_mask,
  output logic                                compared_valid,
  output logic [SYSTOLIC_SIZE-1:0]            compared_ps,
  output logic [SYSTOLIC_SIZE-1:0]            fault_sticky,
  output logic                                fault_any,
  output logic [IDX_WIDTH-1:0]                first_fail_idx,
  output logic                                first_fail_valid,
  output logic                                busy,
  output logic                                done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [IDX_WIDTH-1:0] cnt, idx1;
  logic [SYSTOLIC_SIZE-1:0] mism;
  logic accept;
  for (genvar c = 0; c < SYSTOLIC_SIZE; c++) begin : g_col
    assign mism[c] = (|(correct_answer ^ com_ps[c*DATA_WIDTH +: DATA_WIDTH])) & ~col_mask[c];
  end
  assign accept = (state == RUN) && in_valid && !start;
  always_comb begin
    state_nx = start ? RUN :
               (state == RUN && end_test) ? DRAIN :
               (state == DRAIN) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      idx1             <= '0;
      compared_valid   <= 1'b0;
      compared_ps      <= '0;
      fault_sticky     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state          <= state_nx;
      compared_valid <= accept;
      compared_ps    <= accept ? mism : '0;
      if (start) begin
        cnt              <= '0;
        idx1             <= '0;
        fault_sticky     <= '0;
        first_fail_idx   <= '0;
        first_fail_valid <= 1'b0;
      end else begin
        if (accept) begin
          idx1 <= cnt;
          cnt  <= (&cnt) ? cnt : cnt + 1'b1;
        end
        if (compared_valid) begin
          fault_sticky <= fault_sticky | compared_ps;
          if (|compared_ps && !first_fail_valid) begin
            first_fail_idx   <= idx1;
            first_fail_valid <= 1'b1;
          end
        end
      end
    end
  end
  assign fault_any = |fault_sticky;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
endmodule

// File: doc/comparator_array.md
# comparator_array

Parametrised result comparator for the systolic-array self-test path. Each accepted cycle, it XOR-compares every column's partial sum against the golden answer and flags per-column mismatches. It accumulates sticky per-column fault flags and records the index of the first failing pattern across a test session. It sits between the array's bottom-row partial-sum outputs and the self-recovery controller, which reads `fault_sticky` to decide column remapping.

## Interface
Parameters:
- `SYSTOLIC_SIZE`, 8: number of columns compared.
- `DATA_WIDTH`, 24: partial-sum width.
- `IDX_WIDTH`, 8: pattern counter / first-fail index width.

Ports:
- `clk` input 1: clock. One clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begin (or restart) a test session; clears all session state.
- `end_test` input 1: last pattern has been presented; drain and finish.
- `in_valid` input 1: `correct_answer`/`com_ps` valid this cycle.
- `correct_answer` input DATA_WIDTH: golden partial sum, shared by all columns.
- `com_ps` input SYSTOLIC_SIZE*DATA_WIDTH: column partial sums; column i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `col_mask` input SYSTOLIC_SIZE: 1 = column excluded (already retired); its mismatch is forced 0.
- `compared_valid` output 1: `compared_ps` valid.
- `compared_ps` output SYSTOLIC_SIZE: per-pattern mismatch, bit i = |(correct_answer ^ com_ps[i]) & ~col_mask[i].
- `fault_sticky` output SYSTOLIC_SIZE: OR of all `compared_ps` in the session.
- `fault_any` output 1: |fault_sticky.
- `first_fail_idx` output IDX_WIDTH: 0-based index of the first pattern with any unmasked mismatch.
- `first_fail_valid` output 1: `first_fail_idx` captured.
- `busy` output 1: state is RUN or DRAIN.
- `done` output 1: state is DONE; results final.

## Operation
- FSM states:
  - IDLE, RUN, DRAIN, DONE.
  - Reset → IDLE.
  - `start` in any state → RUN, and clears `fault_sticky`, `first_fail_*`, the pattern counter and the stage-1 registers.
  - RUN with `end_test` (and no `start`) → DRAIN.
  - DRAIN → DONE after 1 cycle.
  - DONE holds until `start` or `rst`.
- `in_valid` is accepted only in RUN, including the cycle `end_test` is high. It is ignored in IDLE, DRAIN and DONE, and in any cycle where `start` is high.
- Stage 1 (per accepted pattern):
  - register `compared_ps` = masked XOR-reduce of each column.
  - `compared_valid` = 1 for exactly one cycle; otherwise `compared_valid` = 0 and `compared_ps` = 0.
- Stage 2 (when `compared_valid` = 1):
  - `fault_sticky` |= `compared_ps`.
  - if `compared_ps` != 0 and `first_fail_valid` = 0: `first_fail_idx` = the pattern index of that result, `first_fail_valid` = 1.
- The pattern index is counted per accepted pattern, starting at 0. It saturates at 2^IDX_WIDTH-1 and does not wrap. Later patterns share the saturated index.
- `col_mask` is sampled with the data. A mask change mid-session does not alter sticky bits already set.
- Comparison is exact bitwise equality; no tolerance and no signedness.

## Timing
- Reset values: all outputs 0, state IDLE.
- Pattern sampled at edge N:
  - `compared_ps` and `compared_valid` are visible after edge N (1-cycle latency).
  - `fault_sticky`, `fault_any` and `first_fail_*` are updated at edge N+1 (2-cycle latency).
- `end_test` sampled at edge N:
  - `busy` stays 1 through DRAIN.
  - `done` = 1 after edge N+1, i.e. in the same cycle the final pattern's sticky update becomes visible.
- `start` and `end_test` in the same cycle: `start` wins and the state goes to RUN.
- `rst` mid-session: all state and outputs return to reset values at the next edge; an in-flight pattern is discarded.
- Full throughput: one pattern per cycle, no backpressure.

## Test plan
- Clean run:
  - Stimulus: `start`; 4 patterns with all columns equal to `correct_answer` = 24'h123456; `end_test` with the 4th.
  - Required: `compared_ps` = 0 each cycle; `done` 2 cycles after `end_test`; `fault_sticky` = 0, `first_fail_valid` = 0.
- Single fault:
  - Stimulus: pattern 2 has column 5 = 24'h123457.
  - Required: `compared_ps` = 8'h20 one cycle after that pattern; `fault_sticky` = 8'h20 and `first_fail_idx` = 2 one cycle later; `fault_any` = 1.
- Mask:
  - Stimulus: `col_mask` = 8'h20, same fault as the single-fault case.
  - Required: `compared_ps` = 0; `fault_sticky` = 0.
  - Stimulus: an additional fault in column 0 at pattern 3.
  - Required: `first_fail_idx` = 3.
- End-of-test boundary and restart:
  - Stimulus: a fault on the pattern presented with `end_test`.
  - Required: it is included in the results and `done` coincides with `fault_sticky` being set.
  - Stimulus: `start` in DONE.
  - Required: all flags are cleared in the next cycle.
- Saturation (IDX_WIDTH = 2):
  - Stimulus: 6 patterns, the first fault at pattern 5.
  - Required: `first_fail_idx` = 3.
- Reset mid-run:
  - Stimulus: assert `rst` the cycle after a faulty pattern.
  - Required: all outputs 0 and IDLE after the edge; no sticky bit set.
  - Stimulus: `in_valid` in IDLE.
  - Required: `compared_valid` stays 0.
